// File: rtl/spike_rate_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_rate_monitor_if
//  Description : Bundles the neuron-side inputs (enable, spike) and the
//                statistics outputs (rate, isi, burst and their valid
//                pulses) of the spike rate monitor into one interface.
//                  master : the driver of enable/spike, consumer of results
//                  slave  : the spike_rate_monitor itself
//                Ports carried:
//                  enable      1      hold all counters/outputs when low
//                  spike       1      raw spike level from the neuron
//                  rate        CNT_W  onset count of last completed window
//                  rate_valid  1      one-cycle pulse when rate updates
//                  isi         ISI_W  last onset-to-onset distance
//                  isi_valid   1      one-cycle pulse when isi updates
//                  burst       1      burst-in-progress level
//  Revision    : 1.0 - initial release
// ============================================================================
interface spike_rate_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             enable;
  logic             spike;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             burst;

  modport master (
    output enable,
    output spike,
    input  rate,
    input  rate_valid,
    input  isi,
    input  isi_valid,
    input  burst
  );

  modport slave (
    input  enable,
    input  spike,
    output rate,
    output rate_valid,
    output isi,
    output isi_valid,
    output burst
  );
endinterface
`default_nettype wire

// File: rtl/spike_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : spike_rate_monitor
//  Description : Watches the 1-bit spike output of a neuron, detects rising
//                edges (onsets) and produces three activity statistics:
//                  - rate  : number of onsets in the last completed window of
//                            WINDOW_CYCLES enabled cycles (saturating)
//                  - isi   : most recent onset-to-onset distance in cycles
//                            (saturating at 2^ISI_W-1)
//                  - burst : high while BURST_LEN consecutive short ISIs
//                            (<= BURST_ISI) have been seen and no long gap
//                            has elapsed since the last onset
//                All outputs are registered. enable=0 freezes every counter
//                and output; the valid pulses are forced low.
//  Ports       : clk    - single clock, rising edge
//                reset  - synchronous, active-high
//                mon    - spike_rate_monitor_if.slave (enable, spike in;
//                         rate/rate_valid/isi/isi_valid/burst out)
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_monitor #(
  parameter int WINDOW_CYCLES = 256,
  parameter int CNT_W         = 8,
  parameter int ISI_W         = 8,
  parameter int BURST_ISI     = 3,
  parameter int BURST_LEN     = 3
) (
  input  wire logic            clk,
  input  wire logic            reset,
  spike_rate_monitor_if.slave  mon
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int RUN_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_ONE  = ISI_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(BURST_LEN);

  // A short-ISI threshold beyond the counter range means every ISI is short.
  localparam logic [ISI_W-1:0] ISI_SHORT =
      (BURST_ISI >= (2 ** ISI_W) - 1) ? ISI_MAX : ISI_W'(BURST_ISI);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             spike_d;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic             seen_first;
  logic [RUN_W-1:0] run;

  logic [CNT_W-1:0] rate_q;
  logic             rate_valid_q;
  logic [ISI_W-1:0] isi_q;
  logic             isi_valid_q;
  logic             burst_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             onset;
  logic             win_last;
  logic [CNT_W-1:0] spike_cnt_inc;
  logic [ISI_W-1:0] isi_cnt_inc;
  logic             isi_long;
  logic [RUN_W-1:0] run_next;

  // spike_d tracks even while disabled, so a level that rose while the
  // block was frozen is not seen as a fresh onset after re-enable.
  assign onset    = mon.enable & mon.spike & ~spike_d;
  assign win_last = (win_cnt == WIN_LAST);

  // Onset count including the current cycle; this is also the value
  // published at window end, so an onset in the last cycle still counts.
  assign spike_cnt_inc = (onset && (spike_cnt != CNT_MAX)) ? spike_cnt + 1'b1
                                                           : spike_cnt;

  assign isi_cnt_inc = (isi_cnt != ISI_MAX) ? isi_cnt + 1'b1 : isi_cnt;

  // isi_cnt at an onset equals the distance to the previous onset.
  assign isi_long = (isi_cnt > ISI_SHORT);

  // Burst run length. A long ISI on an onset breaks the run; between onsets,
  // once the running distance is already long no short ISI can follow, so
  // the run is cleared immediately (timeout) instead of at the next onset.
  always_comb begin
    run_next = run;
    if (onset && seen_first) begin
      if (isi_long) begin
        run_next = '0;
      end else if (run != RUN_MAX) begin
        run_next = run + 1'b1;
      end
    end else if (mon.enable && !onset && seen_first && isi_long) begin
      run_next = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Edge detector register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_d <= 1'b0;
    end else begin
      spike_d <= mon.spike;
    end
  end

  // --------------------------------------------------------------------------
  // Window / rate path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt      <= '0;
      spike_cnt    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (mon.enable) begin
        if (win_last) begin
          win_cnt      <= '0;
          spike_cnt    <= '0;
          rate_q       <= spike_cnt_inc;
          rate_valid_q <= 1'b1;
        end else begin
          win_cnt      <= win_cnt + 1'b1;
          spike_cnt    <= spike_cnt_inc;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Inter-spike interval path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      isi_cnt     <= '0;
      seen_first  <= 1'b0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
    end else begin
      isi_valid_q <= 1'b0;
      if (onset) begin
        // Counting restarts at 1 so the value read at the next onset is the
        // true edge-to-edge distance.
        isi_cnt    <= ISI_ONE;
        seen_first <= 1'b1;
        if (seen_first) begin
          isi_q       <= isi_cnt;
          isi_valid_q <= 1'b1;
        end
      end else if (mon.enable) begin
        isi_cnt <= isi_cnt_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Burst path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      run     <= '0;
      burst_q <= 1'b0;
    end else if (mon.enable) begin
      run     <= run_next;
      burst_q <= (run_next >= RUN_MAX);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mon.rate       = rate_q;
  assign mon.rate_valid = rate_valid_q;
  assign mon.isi        = isi_q;
  assign mon.isi_valid  = isi_valid_q;
  assign mon.burst      = burst_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_rate_monitor
//  Description : Self-checking bench for spike_rate_monitor. Two instances:
//                  dut_a : WINDOW_CYCLES=16, CNT_W=8, ISI_W=8, BURST 3/3
//                  dut_b : WINDOW_CYCLES=32, CNT_W=3, ISI_W=4, BURST 3/3
//                A table of per-cycle vectors drives the burst scenario on
//                dut_a; hand-written sequences cover saturation, reset
//                mid-window, enable gating and held spikes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a;
  logic reset_b;

  spike_rate_monitor_if #(.CNT_W(8), .ISI_W(8)) bus_a ();
  spike_rate_monitor_if #(.CNT_W(3), .ISI_W(4)) bus_b ();

  spike_rate_monitor #(
    .WINDOW_CYCLES(16), .CNT_W(8), .ISI_W(8), .BURST_ISI(3), .BURST_LEN(3)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .mon   (bus_a)
  );

  spike_rate_monitor #(
    .WINDOW_CYCLES(32), .CNT_W(3), .ISI_W(4), .BURST_ISI(3), .BURST_LEN(3)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .mon   (bus_b)
  );

  typedef struct {
    logic       enable;
    logic       spike;
    logic [7:0] rate;
    logic       rate_valid;
    logic [7:0] isi;
    logic       isi_valid;
    logic       burst;
  } vec_t;

  vec_t vt [32];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step_a(input logic rst, input logic en, input logic sp);
    reset_a      = rst;
    bus_a.enable = en;
    bus_a.spike  = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic rst, input logic en, input logic sp);
    reset_b      = rst;
    bus_b.enable = en;
    bus_b.spike  = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int cyc, input logic [7:0] r,
                       input logic rv, input logic [7:0] i, input logic iv,
                       input logic b);
    check({tag, ".rate"},       cyc, 32'(bus_a.rate),       32'(r));
    check({tag, ".rate_valid"}, cyc, 32'(bus_a.rate_valid), 32'(rv));
    check({tag, ".isi"},        cyc, 32'(bus_a.isi),        32'(i));
    check({tag, ".isi_valid"},  cyc, 32'(bus_a.isi_valid),  32'(iv));
    check({tag, ".burst"},      cyc, 32'(bus_a.burst),      32'(b));
  endtask

  task automatic chk_b(input string tag, input int cyc, input logic [2:0] r,
                       input logic rv, input logic [3:0] i, input logic iv,
                       input logic b);
    check({tag, ".rate"},       cyc, 32'(bus_b.rate),       32'(r));
    check({tag, ".rate_valid"}, cyc, 32'(bus_b.rate_valid), 32'(rv));
    check({tag, ".isi"},        cyc, 32'(bus_b.isi),        32'(i));
    check({tag, ".isi_valid"},  cyc, 32'(bus_b.isi_valid),  32'(iv));
    check({tag, ".burst"},      cyc, 32'(bus_b.burst),      32'(b));
  endtask

  initial begin
    // Burst scenario: onsets at 0,2,4,6,20 in a 16-cycle window.
    for (int c = 0; c < 32; c++) begin
      vt[c].enable     = 1'b1;
      vt[c].spike      = (c == 0 || c == 2 || c == 4 || c == 6 || c == 20);
      vt[c].rate       = (c < 15) ? 8'd0 : (c < 31) ? 8'd4 : 8'd1;
      vt[c].rate_valid = (c == 15 || c == 31);
      vt[c].isi        = (c < 2) ? 8'd0 : (c < 20) ? 8'd2 : 8'd14;
      vt[c].isi_valid  = (c == 2 || c == 4 || c == 6 || c == 20);
      vt[c].burst      = (c >= 6 && c < 10);
    end

    // Reset with enable and spike high: reset must win.
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.enable = 1'b1; bus_a.spike = 1'b1;
    bus_b.enable = 1'b1; bus_b.spike = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_a("a_reset", 0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk_b("b_reset", 0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    // dut_a parked (disabled) while dut_b runs.
    reset_a = 1'b0; bus_a.enable = 1'b0; bus_a.spike = 1'b0;

    // dut_b: spike toggling every cycle for one window (16 onsets, rate
    // saturates at 7), then a lone onset at 50 after a gap saturating isi.
    for (int c = 0; c < 64; c++) begin
      step_b(1'b0, 1'b1, (c < 32) ? (c % 2 == 0) : (c == 50));
      chk_b("b_sat", c,
            (c < 31) ? 3'd0 : (c < 63) ? 3'd7 : 3'd1,
            (c == 31 || c == 63),
            (c < 2) ? 4'd0 : (c < 50) ? 4'd2 : 4'd15,
            ((c < 32 && c % 2 == 0 && c >= 2) || c == 50),
            (c >= 6 && c < 34));
    end
    bus_b.enable = 1'b0; bus_b.spike = 1'b0;

    // dut_a: table-driven burst scenario.
    for (int c = 0; c < 32; c++) begin
      step_a(1'b0, vt[c].enable, vt[c].spike);
      chk_a("a_tbl", c, vt[c].rate, vt[c].rate_valid, vt[c].isi,
            vt[c].isi_valid, vt[c].burst);
    end

    // Reset mid-window: 3 onsets, reset at window cycle 9, then 2 onsets.
    for (int c = 0; c < 9; c++) begin
      step_a(1'b0, 1'b1, (c == 0 || c == 3 || c == 6));
    end
    step_a(1'b1, 1'b1, 1'b1);
    chk_a("a_midrst", 9, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int p = 0; p < 16; p++) begin
      step_a(1'b0, 1'b1, (p == 2 || p == 7));
      chk_a("a_postrst", p,
            (p < 15) ? 8'd0 : 8'd2, (p == 15),
            (p < 7) ? 8'd0 : 8'd5, (p == 7), 1'b0);
    end

    // Enable gating: onset at q1, spike rises while disabled (q4..q8) and
    // stays high into q11; window end moves from q15 to q20; the isi count
    // resumes from its held value (onset q21 measures 15 enabled cycles).
    for (int q = 0; q < 22; q++) begin
      step_a(1'b0, !(q >= 4 && q <= 8),
             (q == 1) || (q >= 4 && q <= 11) || (q == 21));
      chk_a("a_enable", q,
            (q < 20) ? 8'd2 : 8'd1, (q == 20),
            (q < 1) ? 8'd5 : (q < 21) ? 8'd10 : 8'd15,
            (q == 1 || q == 21), 1'b0);
    end

    // Spike held for 10 cycles: one onset, no isi.
    step_a(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step_a(1'b0, 1'b1, (c < 10));
      chk_a("a_held", c, (c < 15) ? 8'd0 : 8'd1, (c == 15), 8'd0, 1'b0, 1'b0);
    end

    // Single-cycle spikes every 4 cycles: rate=4 per window, isi=4.
    step_a(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      step_a(1'b0, 1'b1, (c % 4 == 0));
      chk_a("a_every4", c, (c < 15) ? 8'd0 : 8'd4, (c == 15 || c == 31),
            (c < 4) ? 8'd0 : 8'd4, (c % 4 == 0 && c >= 4), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
